multicycle_ctrl: RTL and testbench
==================================

Name: multicycle_ctrl

Overview:
- Main FSM controller for the multicycle RV32I core.
- Sequences fetch, decode, execute, memory and writeback over shared ALU, memory port and immediate extender.
- Drives the 2-bit imm_src select for the immediate extender (I=00, S=01, B=10, J=11).
- Includes a request/ready handshake to memory and per-step ALU control.

Parameters:
- RESET_STATE_ENC, 4'd0: state encoding entered on reset (FETCH). Must equal the FETCH encoding.

Ports:
- clk  in  1  clock
- rst  in  1  async active-high reset
- op  in  7  instr[6:0] from instruction register
- funct3  in  3  instr[14:12]
- funct7b5  in  1  instr[30]
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory completes current access this cycle
- mem_req  out  1  memory access request
- mem_write  out  1  store strobe, qualified by mem_req
- adr_src  out  1  0 = PC, 1 = ALUOut
- ir_write  out  1  load instruction register / old-PC register
- pc_write  out  1  PC enable
- reg_write  out  1  register file write enable
- alu_src_a  out  2  00 PC, 01 old PC, 10 rs1
- alu_src_b  out  2  00 rs2, 01 imm_ext, 10 constant 4
- result_src  out  2  00 ALUOut, 01 read data, 10 ALU result
- alu_control  out  3  000 add, 001 sub, 010 and, 011 or, 101 slt
- imm_src  out  2  immediate format select
- illegal_instr  out  1  present only with the optional feature

Behaviour:
- Clock and reset: one clock, clk. Reset is rst: asynchronous and active-high. While rst=1, state=FETCH and all outputs are 0. Strobes are gated by !rst.
- Outputs: Moore outputs from state, except pc_write in BEQ and the mem_ready-qualified strobes.
- Unlisted outputs are 0 in each state.
- FETCH: mem_req=1, adr_src=0, alu_src_a=00, alu_src_b=10, alu_op=00, result_src=10.
  - ir_write and pc_write are 1 only when mem_ready=1; the state then advances to DECODE.
  - Otherwise the state holds with all strobes 0.
- DECODE: alu_src_a=01, alu_src_b=01, alu_op=00 (branch target into ALUOut). Next state by op:
  - 0000011 or 0100011 -> MEMADR
  - 0110011 -> EXECR
  - 0010011 -> EXECI
  - 1100011 -> BRANCH
  - 1101111 -> JAL
  - anything else -> FETCH
- MEMADR: alu_src_a=10, alu_src_b=01, alu_op=00. Next: op[5]=0 -> MEMREAD, op[5]=1 -> MEMWRITE.
- MEMREAD: mem_req=1, adr_src=1. Holds until mem_ready, then -> MEMWB.
- MEMWB: result_src=01, reg_write=1 -> FETCH.
- MEMWRITE: mem_req=1, mem_write=1, adr_src=1. Holds until mem_ready, then -> FETCH. mem_write stays asserted for the whole wait.
- EXECR: alu_src_a=10, alu_src_b=00, alu_op=10 -> ALUWB.
- EXECI: alu_src_a=10, alu_src_b=01, alu_op=10 -> ALUWB.
- ALUWB: result_src=00, reg_write=1 -> FETCH.
- BRANCH: alu_src_a=10, alu_src_b=00, alu_op=01, result_src=00.
  - pc_write = zero XOR funct3[0] (beq/bne); other funct3 values are not taken.
  - Next state -> FETCH.
- JAL: alu_src_a=01, alu_src_b=10, alu_op=00, result_src=00, pc_write=1 -> ALUWB (rd = old PC + 4).
- imm_src: combinational from op in every state.
  - 0100011 -> 01; 1100011 -> 10; 1101111 -> 11; else 00.
- ALU decoder:
  - alu_op 00 -> add; 01 -> sub.
  - alu_op 10, by funct3:
    - 000 -> sub when op[5] & funct7b5, else add
    - 010 -> slt
    - 110 -> or
    - 111 -> and
    - others -> add
- Latency (mem_ready tied 1): R/I = 4 cycles, lw = 5, sw = 4, branch = 3, jal = 4.
- Reset mid-access drops mem_req in the same cycle. No partial writeback occurs.

Optional Feature:
- Macro: MULTICYCLE_CTRL_TRAP_EN.
- When defined:
  - Adds state TRAP and output illegal_instr.
  - Illegal conditions: DECODE with an unsupported op, or EXECR/EXECI with an unsupported funct3. Either goes to TRAP.
  - TRAP holds until reset, with illegal_instr=1 and all strobes 0.
- When undefined:
  - No port and no state.
  - Unsupported op returns to FETCH as a NOP; unsupported funct3 executes as add.

Test Plan:
- add x3,x1,x2 (0x002081B3), mem_ready=1 -> FETCH, DECODE, EXECR, ALUWB. alu_control=000 in EXECR, reg_write=1 in ALUWB only, then back to FETCH.
- lw (0x0000A183) with mem_ready low 3 cycles in MEMREAD -> mem_req and adr_src=1 held 4 cycles, MEMWB with result_src=01, imm_src=00, total 8 cycles.
- sw (0x0020A023) -> imm_src=01. mem_write=1 only in MEMWRITE, held until mem_ready, reg_write never asserted.
- beq with zero=1 -> pc_write=1 in BRANCH, alu_control=001, imm_src=10. With zero=0 -> pc_write=0. bne inverts both results.
- jal (0x008000EF) -> imm_src=11. pc_write=1 in JAL, then ALUWB with reg_write=1.
- rst asserted mid-MEMWRITE -> all outputs 0 in the same cycle. After release: FETCH, mem_req=1. With TRAP_EN, op=0x7F -> TRAP, illegal_instr=1, sticky until rst.

Source files
------------

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: main FSM controller for the multicycle RV32I core.
// Sequences fetch/decode/execute/memory/writeback over a shared ALU,
// memory port and immediate extender, with a mem_req/mem_ready handshake.
// Optional feature macro: MULTICYCLE_CTRL_TRAP_EN (adds TRAP state and
// the illegal_instr output).
module multicycle_ctrl #(
   parameter logic [3:0] RESET_STATE_ENC = 4'd0
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [6:0] op,
   input  logic [2:0] funct3,
   input  logic       funct7b5,
   input  logic       zero,
   input  logic       mem_ready,
   output logic       mem_req,
   output logic       mem_write,
   output logic       adr_src,
   output logic       ir_write,
   output logic       pc_write,
   output logic       reg_write,
   output logic [1:0] alu_src_a,
   output logic [1:0] alu_src_b,
   output logic [1:0] result_src,
   output logic [2:0] alu_control,
   output logic [1:0] imm_src
`ifdef MULTICYCLE_CTRL_TRAP_EN
  ,output logic       illegal_instr
`endif
);

   localparam logic [6:0] OP_LOAD  = 7'b0000011;
   localparam logic [6:0] OP_STORE = 7'b0100011;
   localparam logic [6:0] OP_R     = 7'b0110011;
   localparam logic [6:0] OP_I     = 7'b0010011;
   localparam logic [6:0] OP_BR    = 7'b1100011;
   localparam logic [6:0] OP_JAL   = 7'b1101111;

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEMADR   = 4'd2,
      S_MEMREAD  = 4'd3,
      S_MEMWB    = 4'd4,
      S_MEMWRITE = 4'd5,
      S_EXECR    = 4'd6,
      S_EXECI    = 4'd7,
      S_ALUWB    = 4'd8,
      S_BRANCH   = 4'd9,
      S_JAL      = 4'd10
`ifdef MULTICYCLE_CTRL_TRAP_EN
     ,S_TRAP     = 4'd11
`endif
   } state_t;

   state_t state_q, state_d;

   // Raw (ungated) control values; everything is forced low while rst is high.
   logic       req_c, wr_c, adr_c, irw_c, pcw_c, rw_c, ill_c;
   logic [1:0] sa_c, sb_c, rs_c, alu_op_c, imm_c;
   logic [2:0] ac_c;
   logic       f3_ok;

   // Only these funct3 codes have a real ALU operation behind them.
   assign f3_ok = (funct3 == 3'b000) || (funct3 == 3'b010) ||
                  (funct3 == 3'b110) || (funct3 == 3'b111);

   // State register, reset lands on the FETCH encoding.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= state_t'(RESET_STATE_ENC);
      else     state_q <= state_d;
   end

   // Next-state and Moore outputs; pc/ir strobes in FETCH and pc_write in
   // BRANCH are the only input-qualified outputs.
   always_comb begin
      state_d  = state_q;
      req_c    = 1'b0;
      wr_c     = 1'b0;
      adr_c    = 1'b0;
      irw_c    = 1'b0;
      pcw_c    = 1'b0;
      rw_c     = 1'b0;
      ill_c    = 1'b0;
      sa_c     = 2'b00;
      sb_c     = 2'b00;
      rs_c     = 2'b00;
      alu_op_c = 2'b00;
      case (state_q)
         S_FETCH: begin
            req_c = 1'b1;
            sb_c  = 2'b10;
            rs_c  = 2'b10;
            if (mem_ready) begin
               irw_c   = 1'b1;
               pcw_c   = 1'b1;
               state_d = S_DECODE;
            end
         end
         S_DECODE: begin
            sa_c = 2'b01;
            sb_c = 2'b01;
            case (op)
               OP_LOAD, OP_STORE: state_d = S_MEMADR;
               OP_R:              state_d = S_EXECR;
               OP_I:              state_d = S_EXECI;
               OP_BR:             state_d = S_BRANCH;
               OP_JAL:            state_d = S_JAL;
`ifdef MULTICYCLE_CTRL_TRAP_EN
               default:           state_d = S_TRAP;
`else
               default:           state_d = S_FETCH;
`endif
            endcase
         end
         S_MEMADR: begin
            sa_c    = 2'b10;
            sb_c    = 2'b01;
            state_d = op[5] ? S_MEMWRITE : S_MEMREAD;
         end
         S_MEMREAD: begin
            req_c = 1'b1;
            adr_c = 1'b1;
            if (mem_ready) state_d = S_MEMWB;
         end
         S_MEMWB: begin
            rs_c    = 2'b01;
            rw_c    = 1'b1;
            state_d = S_FETCH;
         end
         S_MEMWRITE: begin
            req_c = 1'b1;
            wr_c  = 1'b1;
            adr_c = 1'b1;
            if (mem_ready) state_d = S_FETCH;
         end
         S_EXECR, S_EXECI: begin
            sa_c     = 2'b10;
            sb_c     = (state_q == S_EXECI) ? 2'b01 : 2'b00;
            alu_op_c = 2'b10;
`ifdef MULTICYCLE_CTRL_TRAP_EN
            state_d  = f3_ok ? S_ALUWB : S_TRAP;
`else
            state_d  = S_ALUWB;
`endif
         end
         S_ALUWB: begin
            rw_c    = 1'b1;
            state_d = S_FETCH;
         end
         S_BRANCH: begin
            sa_c     = 2'b10;
            alu_op_c = 2'b01;
            // beq takes on zero, bne on !zero; other compares never taken
            pcw_c    = (funct3[2:1] == 2'b00) && (zero ^ funct3[0]);
            state_d  = S_FETCH;
         end
         S_JAL: begin
            sa_c    = 2'b01;
            sb_c    = 2'b10;
            pcw_c   = 1'b1;
            state_d = S_ALUWB;
         end
`ifdef MULTICYCLE_CTRL_TRAP_EN
         S_TRAP: begin
            ill_c   = 1'b1;
            state_d = S_TRAP;
         end
`endif
         default: state_d = S_FETCH;
      endcase
   end

   // ALU decoder: alu_op selects add/sub directly or defers to funct3.
   always_comb begin
      ac_c = 3'b000;
      case (alu_op_c)
         2'b01: ac_c = 3'b001;
         2'b10: begin
            case (funct3)
               3'b000:  ac_c = (op[5] & funct7b5) ? 3'b001 : 3'b000;
               3'b010:  ac_c = 3'b101;
               3'b110:  ac_c = 3'b011;
               3'b111:  ac_c = 3'b010;
               default: ac_c = 3'b000;
            endcase
         end
         default: ac_c = 3'b000;
      endcase
   end

   // Immediate format select, purely from the opcode.
   always_comb begin
      case (op)
         OP_STORE: imm_c = 2'b01;
         OP_BR:    imm_c = 2'b10;
         OP_JAL:   imm_c = 2'b11;
         default:  imm_c = 2'b00;
      endcase
   end

   // Gate every output with !rst so a reset mid-access drops the bus at once.
   always_comb begin
      mem_req     = req_c & ~rst;
      mem_write   = wr_c  & ~rst;
      adr_src     = adr_c & ~rst;
      ir_write    = irw_c & ~rst;
      pc_write    = pcw_c & ~rst;
      reg_write   = rw_c  & ~rst;
      alu_src_a   = rst ? 2'b00  : sa_c;
      alu_src_b   = rst ? 2'b00  : sb_c;
      result_src  = rst ? 2'b00  : rs_c;
      alu_control = rst ? 3'b000 : ac_c;
      imm_src     = rst ? 2'b00  : imm_c;
   end

`ifdef MULTICYCLE_CTRL_TRAP_EN
   assign illegal_instr = ill_c & ~rst;
`else
   // ill_c and f3_ok only matter to the trap logic.
   logic unused_trap;
   assign unused_trap = ill_c ^ f3_ok;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: directed + randomized checks of multicycle_ctrl against
// a per-instruction expected cycle sequence built from the instruction rules.
module tb_multicycle_ctrl;

   localparam logic [6:0] OP_LOAD  = 7'b0000011;
   localparam logic [6:0] OP_STORE = 7'b0100011;
   localparam logic [6:0] OP_R     = 7'b0110011;
   localparam logic [6:0] OP_I     = 7'b0010011;
   localparam logic [6:0] OP_BR    = 7'b1100011;
   localparam logic [6:0] OP_JAL   = 7'b1101111;
   localparam logic [2:0] ADD = 3'b000, SUB = 3'b001, AND_ = 3'b010,
                          OR_ = 3'b011, SLT = 3'b101;

   logic clk = 1'b0;
   logic rst;
   logic [6:0] op;
   logic [2:0] funct3;
   logic funct7b5, zero, mem_ready;
   logic mem_req, mem_write, adr_src, ir_write, pc_write, reg_write;
   logic [1:0] alu_src_a, alu_src_b, result_src, imm_src;
   logic [2:0] alu_control;
`ifdef MULTICYCLE_CTRL_TRAP_EN
   logic illegal_instr;
`endif

   int checks = 0;
   int errors = 0;
   bit       q_rdy[$];
   logic [16:0] q_exp[$];

   always #5 clk = ~clk;

   multicycle_ctrl dut (
      .clk(clk), .rst(rst), .op(op), .funct3(funct3), .funct7b5(funct7b5),
      .zero(zero), .mem_ready(mem_ready), .mem_req(mem_req),
      .mem_write(mem_write), .adr_src(adr_src), .ir_write(ir_write),
      .pc_write(pc_write), .reg_write(reg_write), .alu_src_a(alu_src_a),
      .alu_src_b(alu_src_b), .result_src(result_src),
      .alu_control(alu_control), .imm_src(imm_src)
`ifdef MULTICYCLE_CTRL_TRAP_EN
     ,.illegal_instr(illegal_instr)
`endif
   );

   logic [16:0] obs;
   assign obs = {mem_req, mem_write, adr_src, ir_write, pc_write, reg_write,
                 alu_src_a, alu_src_b, result_src, alu_control, imm_src};

   function automatic logic [16:0] v(input bit req, wr, adr, irw, pcw, rw,
                                     input logic [1:0] sa, sb, rs,
                                     input logic [2:0] ac, input logic [1:0] im);
      return {req, wr, adr, irw, pcw, rw, sa, sb, rs, ac, im};
   endfunction

   function automatic logic [1:0] imm_of(input logic [6:0] o);
      if (o == OP_STORE) return 2'b01;
      if (o == OP_BR)    return 2'b10;
      if (o == OP_JAL)   return 2'b11;
      return 2'b00;
   endfunction

   // ALU operation the instruction asks for (sub only for R-type with bit 30).
   function automatic logic [2:0] arith_of(input logic [6:0] o, input logic [2:0] f3,
                                           input logic f7);
      case (f3)
         3'd0:    return (o == OP_R && f7) ? SUB : ADD;
         3'd2:    return SLT;
         3'd6:    return OR_;
         3'd7:    return AND_;
         default: return ADD;
      endcase
   endfunction

   function automatic bit rb();
      return bit'($urandom_range(0, 1));
   endfunction

   task automatic chk(input string tag, input logic [16:0] got, input logic [16:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // One clock: drive mem_ready just after posedge, compare at negedge.
   task automatic step(input bit rdy, input logic [16:0] e, input string tag);
      mem_ready = rdy;
      @(negedge clk);
      chk(tag, obs, e);
      @(posedge clk);
      #1;
   endtask

   task automatic push(input bit r, input logic [16:0] e);
      q_rdy.push_back(r);
      q_exp.push_back(e);
   endtask

   // Expected cycle-by-cycle outputs of one instruction.
   task automatic build(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                        input logic z, input int wf, input int wm);
      logic [1:0] im;
      bit taken;
      im = imm_of(o);
      q_rdy.delete();
      q_exp.delete();
      repeat (wf) push(1'b0, v(1,0,0,0,0,0, 2'b00,2'b10,2'b10, ADD, im));
      push(1'b1, v(1,0,0,1,1,0, 2'b00,2'b10,2'b10, ADD, im));
      push(rb(), v(0,0,0,0,0,0, 2'b01,2'b01,2'b00, ADD, im));
      case (o)
         OP_LOAD: begin
            push(rb(), v(0,0,0,0,0,0, 2'b10,2'b01,2'b00, ADD, im));
            repeat (wm) push(1'b0, v(1,0,1,0,0,0, 2'b00,2'b00,2'b00, ADD, im));
            push(1'b1, v(1,0,1,0,0,0, 2'b00,2'b00,2'b00, ADD, im));
            push(rb(), v(0,0,0,0,0,1, 2'b00,2'b00,2'b01, ADD, im));
         end
         OP_STORE: begin
            push(rb(), v(0,0,0,0,0,0, 2'b10,2'b01,2'b00, ADD, im));
            repeat (wm) push(1'b0, v(1,1,1,0,0,0, 2'b00,2'b00,2'b00, ADD, im));
            push(1'b1, v(1,1,1,0,0,0, 2'b00,2'b00,2'b00, ADD, im));
         end
         OP_R, OP_I: begin
            push(rb(), v(0,0,0,0,0,0, 2'b10, (o == OP_I) ? 2'b01 : 2'b00, 2'b00,
                         arith_of(o, f3, f7), im));
            push(rb(), v(0,0,0,0,0,1, 2'b00,2'b00,2'b00, ADD, im));
         end
         OP_BR: begin
            taken = (f3 == 3'd0) ? z : (f3 == 3'd1) ? !z : 1'b0;
            push(rb(), v(0,0,0,0,taken,0, 2'b10,2'b00,2'b00, SUB, im));
         end
         OP_JAL: begin
            push(rb(), v(0,0,0,0,1,0, 2'b01,2'b10,2'b00, ADD, im));
            push(rb(), v(0,0,0,0,0,1, 2'b00,2'b00,2'b00, ADD, im));
         end
         default: ;
      endcase
   endtask

   task automatic run_instr(input string name, input logic [6:0] o, input logic [2:0] f3,
                            input logic f7, input logic z, input int wf, input int wm);
      op = o; funct3 = f3; funct7b5 = f7; zero = z;
      build(o, f3, f7, z, wf, wm);
      foreach (q_exp[i]) step(q_rdy[i], q_exp[i], $sformatf("%s.c%0d", name, i));
   endtask

   initial begin
      logic [6:0] o;
      logic [2:0] f3;
      int k;
      rst = 1'b1; op = OP_JAL; funct3 = 3'd0; funct7b5 = 1'b0; zero = 1'b0;
      mem_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("reset_outputs", obs, 17'd0);
      rst = 1'b0;

      // Directed sequences from the instruction encodings.
      run_instr("add",  OP_R,     3'd0, 1'b0, 1'b0, 0, 0);
      run_instr("sub",  OP_R,     3'd0, 1'b1, 1'b0, 0, 0);
      run_instr("lw",   OP_LOAD,  3'd2, 1'b0, 1'b0, 0, 3);
      run_instr("sw",   OP_STORE, 3'd2, 1'b0, 1'b0, 1, 2);
      run_instr("beq1", OP_BR,    3'd0, 1'b0, 1'b1, 0, 0);
      run_instr("beq0", OP_BR,    3'd0, 1'b0, 1'b0, 0, 0);
      run_instr("bne1", OP_BR,    3'd1, 1'b0, 1'b1, 0, 0);
      run_instr("bne0", OP_BR,    3'd1, 1'b0, 1'b0, 0, 0);
      run_instr("blt",  OP_BR,    3'd4, 1'b0, 1'b1, 0, 0);
      run_instr("jal",  OP_JAL,   3'd0, 1'b0, 1'b0, 0, 0);
      run_instr("ori",  OP_I,     3'd6, 1'b1, 1'b0, 2, 0);

      // Reset in the middle of a stalled store.
      op = OP_STORE; funct3 = 3'd2; funct7b5 = 1'b0;
      step(1'b1, v(1,0,0,1,1,0, 2'b00,2'b10,2'b10, ADD, 2'b01), "rst.fetch");
      step(1'b0, v(0,0,0,0,0,0, 2'b01,2'b01,2'b00, ADD, 2'b01), "rst.decode");
      step(1'b0, v(0,0,0,0,0,0, 2'b10,2'b01,2'b00, ADD, 2'b01), "rst.memadr");
      mem_ready = 1'b0;
      @(negedge clk);
      chk("rst.memwrite", obs, v(1,1,1,0,0,0, 2'b00,2'b00,2'b00, ADD, 2'b01));
      #1 rst = 1'b1;
      #1 chk("rst.async_drop", obs, 17'd0);
      @(posedge clk);
      #1 chk("rst.hold", obs, 17'd0);
      rst = 1'b0;
      step(1'b0, v(1,0,0,0,0,0, 2'b00,2'b10,2'b10, ADD, 2'b01), "rst.refetch");
      run_instr("sw_after_rst", OP_STORE, 3'd2, 1'b0, 1'b0, 0, 0);

      // Randomized instruction stream.
      for (int n = 0; n < 60; n++) begin
         k  = $urandom_range(0, 6);
         f3 = 3'($urandom_range(0, 7));
`ifdef MULTICYCLE_CTRL_TRAP_EN
         if (k == 6) k = 0;
         if (k <= 1) begin
            case ($urandom_range(0, 3))
               0: f3 = 3'd0; 1: f3 = 3'd2; 2: f3 = 3'd6; default: f3 = 3'd7;
            endcase
         end
`endif
         case (k)
            0: o = OP_R;
            1: o = OP_I;
            2: o = OP_LOAD;
            3: o = OP_STORE;
            4: o = OP_BR;
            5: o = OP_JAL;
            default: begin
               o = 7'($urandom_range(0, 127));
               while (o == OP_R || o == OP_I || o == OP_LOAD || o == OP_STORE ||
                      o == OP_BR || o == OP_JAL)
                  o = 7'($urandom_range(0, 127));
            end
         endcase
         run_instr($sformatf("rnd%0d_op%h_f%0d", n, o, f3), o, f3, rb(), rb(),
                   $urandom_range(0, 3), $urandom_range(0, 3));
      end

`ifdef MULTICYCLE_CTRL_TRAP_EN
      // Illegal opcode traps and stays trapped until reset.
      op = 7'h7F; funct3 = 3'd0;
      step(1'b1, v(1,0,0,1,1,0, 2'b00,2'b10,2'b10, ADD, 2'b00), "trap.fetch");
      step(1'b1, v(0,0,0,0,0,0, 2'b01,2'b01,2'b00, ADD, 2'b00), "trap.decode");
      for (int t = 0; t < 3; t++) begin
         mem_ready = rb();
         @(negedge clk);
         chk($sformatf("trap.out%0d", t), obs, 17'd0);
         chk($sformatf("trap.ill%0d", t), {16'd0, illegal_instr}, 17'd1);
         @(posedge clk);
         #1;
      end
      rst = 1'b1;
      #1 chk("trap.rst_ill", {16'd0, illegal_instr}, 17'd0);
      @(posedge clk);
      #1 rst = 1'b0;
      run_instr("after_trap", OP_R, 3'd7, 1'b0, 1'b0, 0, 0);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
